// File: rtl/huff_bit_packer.sv
// LSB-first variable-length code packer for the deflate back end.
// Emits full OUT_W-bit words and a final partial word on end of stream.
module huff_bit_packer #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 64,
  parameter int LEN_W  = $clog2(IN_W + 1),
  parameter int BITS_W = $clog2(OUT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [BITS_W-1:0] out_bits,
  output logic              out_last
);

  localparam int ACC_W  = OUT_W + IN_W;
  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_W);
  localparam logic [LEN_W-1:0]  IN_L  = LEN_W'(IN_W);
  localparam logic [BITS_W-1:0] OUT_B = BITS_W'(OUT_W);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [ACC_W-1:0]  acc_q, acc_d, acc_sh;
  logic [FILL_W-1:0] fill_q, fill_d, fill_sh;
  logic [0:0]        st_q, st_d;

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic [BITS_W-1:0] out_bits_q, out_bits_d;
  logic              out_last_q, out_last_d;

  logic [LEN_W-1:0]  len_sat;
  logic [IN_W-1:0]   code_m;
  logic              slot_free;
  logic              full;
  logic              emit_a;
  logic              emit_f;
  logic              emit;
  logic              fin;
  logic              rdy;
  logic              accept;

  assign len_sat   = (in_len > IN_L) ? IN_L : in_len;
  assign code_m    = in_data & ~({IN_W{1'b1}} << len_sat);
  assign slot_free = !out_valid_q || out_ready;
  assign full      = fill_q >= OUT_F;

  assign emit_a = (st_q == ACCUM) && full && slot_free;
  assign emit_f = (st_q == FLUSH) && (fill_q > OUT_F) && slot_free;
  assign fin    = (st_q == FLUSH) && !(fill_q > OUT_F) && slot_free;
  assign emit   = emit_a || emit_f;

  assign rdy      = (st_q == ACCUM) && (!full || emit_a);
  assign in_ready = reset && rdy;
  assign accept   = in_valid && in_ready;

  assign acc_sh  = emit ? (acc_q >> OUT_W) : acc_q;
  assign fill_sh = emit ? (fill_q - OUT_F) : fill_q;

  always_comb begin
    acc_d  = acc_sh;
    fill_d = fill_sh;
    st_d   = st_q;
    if (accept) begin
      acc_d  = acc_sh | (ACC_W'(code_m) << fill_sh);
      fill_d = fill_sh + FILL_W'(len_sat);
      if (in_last) st_d = FLUSH;
    end
    if (fin) begin
      acc_d  = '0;
      fill_d = '0;
      st_d   = ACCUM;
    end
  end

  // Output slot: a new load wins over a pending drain.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_bits_d  = out_bits_q;
    out_last_d  = out_last_q;
    unique case (1'b1)
      emit: begin
        out_valid_d = 1'b1;
        out_data_d  = acc_q[OUT_W-1:0];
        out_bits_d  = OUT_B;
        out_last_d  = 1'b0;
      end
      fin: begin
        out_valid_d = 1'b1;
        out_data_d  = acc_q[OUT_W-1:0]
                    & ~({OUT_W{1'b1}} << fill_q);
        out_bits_d  = BITS_W'(fill_q);
        out_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      fill_q      <= '0;
      st_q        <= ACCUM;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bits  = out_bits_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_huff_bit_packer.sv
// Randomized bench for huff_bit_packer against a bit-queue model.
// Streams are driven and observed mid-cycle, away from the rising edge.
module tb_huff_bit_packer;

  localparam int IN_W   = 32;
  localparam int OUT_W  = 64;
  localparam int LEN_W  = 6;
  localparam int BITS_W = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN_W-1:0]   in_data = '0;
  logic [LEN_W-1:0]  in_len = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic [BITS_W-1:0] out_bits;
  logic              out_last;

  huff_bit_packer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W), .BITS_W(BITS_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bits(out_bits), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] cd[$];
  int          cl[$];
  logic [63:0] ed[$];
  int          eb[$];
  bit          el[$];
  logic [63:0] gd[$];
  int          gb[$];
  bit          gl[$];

  // Reference: concatenate masked code bits, cut into 64-bit words.
  task automatic build_model();
    bit          bq[$];
    int          l;
    int          n;
    logic [63:0] w;
    ed.delete(); eb.delete(); el.delete();
    foreach (cd[i]) begin
      l = (cl[i] > IN_W) ? IN_W : cl[i];
      for (int b = 0; b < l; b++) bq.push_back(cd[i][b]);
    end
    if (bq.size() == 0) begin
      ed.push_back('0); eb.push_back(0); el.push_back(1'b1);
    end else begin
      while (bq.size() > 0) begin
        w = '0;
        n = 0;
        while (n < OUT_W && bq.size() > 0) begin
          w[n] = bq.pop_front();
          n++;
        end
        ed.push_back(w); eb.push_back(n); el.push_back(bq.size() == 0);
      end
    end
  endtask

  task automatic run_stream(input string nm, input int pv, input int pr,
                            input int hold, input int hold_acc);
    int          idx = 0;
    int          cyc = 0;
    int          acc_hold = 0;
    bit          done = 0;
    bit          rdy_ok = 1;
    bit          stall = 0;
    logic [63:0] pd = '0;
    logic [6:0]  pb = '0;
    bit          pl = 0;
    int          n;
    build_model();
    gd.delete(); gb.delete(); gl.delete();
    while (!done && cyc < 4000) begin
      @(negedge clk);
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_bits !== pb ||
            out_last !== pl) begin
          errors++;
          $display("FAIL %s hold: got v=%b d=%h b=%0d l=%b want v=1 d=%h b=%0d l=%b",
                   nm, out_valid, out_data, out_bits, out_last, pd, pb, pl);
        end
      end
      out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pr);
      if (idx < cd.size()) begin
        in_valid = ($urandom_range(99) < pv);
        in_data  = cd[idx];
        in_len   = LEN_W'(cl[idx]);
        in_last  = (idx == cd.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_len   = LEN_W'($urandom);
        in_last  = 1'($urandom);
      end
      #1;
      if (idx < cd.size() && in_ready !== 1'b1) rdy_ok = 0;
      if (in_valid && in_ready) begin
        idx++;
        if (cyc < hold) acc_hold++;
      end
      if (out_valid && out_ready) begin
        gd.push_back(out_data); gb.push_back(int'(out_bits));
        gl.push_back(out_last);
        if (out_last) done = 1;
      end
      stall = out_valid && !out_ready;
      pd = out_data; pb = out_bits; pl = out_last;
      if (hold > 0 && cyc == hold - 1) begin
        checks++;
        if (acc_hold != hold_acc || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_accepts: got %0d rdy=%b want %0d rdy=0",
                   nm, acc_hold, in_ready, hold_acc);
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got %0d words want %0d", nm, gd.size(),
               ed.size());
    end
    checks++;
    if (gd.size() != ed.size()) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d", nm, gd.size(), ed.size());
    end
    n = (gd.size() < ed.size()) ? gd.size() : ed.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gd[i] !== ed[i] || gb[i] != eb[i] || gl[i] != el[i]) begin
        errors++;
        $display("FAIL %s word%0d: got %h/%0d/%b want %h/%0d/%b", nm, i,
                 gd[i], gb[i], gl[i], ed[i], eb[i], el[i]);
      end
    end
    if (pr == 100 && hold == 0 && pv == 100) begin
      checks++;
      if (!rdy_ok) begin
        errors++;
        $display("FAIL %s in_ready: got drop want steady 1", nm);
      end
    end
  endtask

  task automatic set_codes1(input logic [31:0] d, input int l);
    cd.delete(); cl.delete();
    cd.push_back(d); cl.push_back(l);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      in_len    = LEN_W'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      checks++;
      if ({in_ready, out_valid, out_data, out_bits, out_last} !== '0) begin
        errors++;
        $display("FAIL reset_hold: got rdy=%b v=%b d=%h b=%0d l=%b want all 0",
                 in_ready, out_valid, out_data, out_bits, out_last);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_small();
    cd.delete(); cl.delete();
    cd.push_back(32'h1); cl.push_back(1);
    cd.push_back(32'h3); cl.push_back(2);
    run_stream("small", 100, 100, 0, 0);
    checks++;
    if (gd.size() < 1 || gd[0] !== 64'h7 || gb[0] != 3 || gl[0] != 1'b1) begin
      errors++;
      $display("FAIL small_const: got %0d words want 0x7/3/last", gd.size());
    end
  endtask

  task automatic test_mask_sat();
    set_codes1(32'hFFFF_FFFF, 4);
    run_stream("mask", 100, 100, 0, 0);
    checks++;
    if (gd.size() < 1 || gd[0] !== 64'hF || gb[0] != 4) begin
      errors++;
      $display("FAIL mask_const: got %0d words want 0xF/4", gd.size());
    end
    set_codes1(32'hFFFF_FFFF, 40);
    run_stream("sat", 100, 100, 0, 0);
    checks++;
    if (gd.size() < 1 || gd[0] !== 64'hFFFF_FFFF || gb[0] != 32) begin
      errors++;
      $display("FAIL sat_const: got %0d words want 0xffffffff/32", gd.size());
    end
  endtask

  task automatic test_full_stream();
    logic [31:0] a, b, c, d;
    int          extra = 0;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    cd.delete(); cl.delete();
    cd.push_back(a); cd.push_back(b); cd.push_back(c); cd.push_back(d);
    for (int i = 0; i < 4; i++) cl.push_back(32);
    run_stream("full", 100, 100, 0, 0);
    checks++;
    if (gd.size() != 2 || gd[0] !== {b, a} || gd[1] !== {d, c} ||
        gb[0] != 64 || gb[1] != 64 || gl[0] != 0 || gl[1] != 1) begin
      errors++;
      $display("FAIL full_const: got %0d words want {B,A}/64/0 {D,C}/64/1",
               gd.size());
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL full_extra: got %0d extra valid cycles want 0", extra);
    end
  endtask

  task automatic test_backpressure();
    cd.delete(); cl.delete();
    for (int i = 0; i < 5; i++) begin
      cd.push_back(32'hAAAA_AAAA); cl.push_back(32);
    end
    run_stream("bp", 100, 100, 12, 4);
  endtask

  task automatic test_empty();
    set_codes1($urandom, 0);
    run_stream("empty", 100, 100, 0, 0);
    checks++;
    if (gd.size() != 1 || gd[0] !== 64'h0 || gb[0] != 0 || gl[0] != 1'b1) begin
      errors++;
      $display("FAIL empty_const: got %0d words want one 0/0/last", gd.size());
    end
  endtask

  task automatic test_reset_flush();
    int n = 0;
    int cyc = 0;
    while (n < 3 && cyc < 50) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = $urandom;
      in_len    = LEN_W'(32);
      in_last   = (n == 2);
      #1;
      if (in_ready) n++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (n != 3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rflush_setup: got n=%0d v=%b rdy=%b want 3/1/0",
               n, out_valid, in_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_bits, out_last} !== '0) begin
      errors++;
      $display("FAIL rflush_clear: got rdy=%b v=%b d=%h b=%0d l=%b want all 0",
               in_ready, out_valid, out_data, out_bits, out_last);
    end
    @(negedge clk);
    reset = 1'b1;
    set_codes1(32'hFFFF_FFF5, 3);
    run_stream("rflush_next", 100, 100, 0, 0);
    checks++;
    if (gd.size() != 1 || gd[0] !== 64'h5 || gb[0] != 3) begin
      errors++;
      $display("FAIL rflush_next_const: got %0d words want 0x5/3", gd.size());
    end
  endtask

  task automatic test_random();
    int nc;
    for (int s = 0; s < 14; s++) begin
      cd.delete(); cl.delete();
      nc = $urandom_range(24, 1);
      for (int i = 0; i < nc; i++) begin
        cd.push_back($urandom);
        cl.push_back($urandom_range(40, 0));
      end
      run_stream($sformatf("rand%0d", s), $urandom_range(100, 40),
                 $urandom_range(100, 30), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_mask_sat();
    test_full_stream();
    test_backpressure();
    test_empty();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/huff_bit_packer.md
# huff_bit_packer

Parametrised LSB-first bit packer for the deflate encoder back end. It accepts variable-length Huffman/extra-bit codes of 0..IN_W bits and concatenates them into a bit accumulator. It emits full OUT_W-bit words over a valid/ready handshake and flushes a final partial word, with its valid-bit count, on end of stream. It sits between the code generator and the output-word FIFO, and replaces fixed-width accumulate-and-shift registers with a streaming, backpressured, parametrised packer.

## Interface
- IN_W, 32, maximum code length in bits; IN_W ≤ OUT_W required
- OUT_W, 64, output word width in bits
- LEN_W, $clog2(IN_W+1), width of in_len
- BITS_W, $clog2(OUT_W+1), width of out_bits

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  code present
- in_ready  out  1  packer accepts code this cycle
- in_data  in  IN_W  code bits, LSB first; bits at index ≥ in_len ignored
- in_len  in  LEN_W  code length 0..IN_W; values > IN_W saturate to IN_W
- in_last  in  1  final code of stream; starts flush
- out_valid  out  1  output word held
- out_ready  in  1  downstream accepts word
- out_data  out  OUT_W  packed word, first bit at LSB; bits ≥ out_bits are 0
- out_bits  out  BITS_W  valid bits in out_data (OUT_W for full words)
- out_last  out  1  final word of stream

## Operation
- State: accumulator acc (OUT_W+IN_W bits), fill count, FSM {ACCUM, FLUSH}, one registered output slot.
- slot_free = !out_valid || out_ready.
- emit (ACCUM) = fill ≥ OUT_W && slot_free. On emit: load acc[OUT_W-1:0] into out_data, set out_bits=OUT_W, out_last=0, and shift acc right by OUT_W.
- in_ready = reset && state==ACCUM && (fill < OUT_W || emit).
- On accept (in_valid && in_ready): let f' = fill − (emit ? OUT_W : 0). Then acc ← (acc>>emit·OUT_W) | (masked in_data << f'), and fill ← f' + len.
- Invariant: fill ≤ OUT_W−1+IN_W. The accumulator never overflows.
- Accept with in_last=1 moves to FLUSH. The same-cycle emit still happens.
- FLUSH: in_ready=0.
  - If fill > OUT_W and slot_free: emit a normal full word.
  - If fill ≤ OUT_W and slot_free: load the final word (out_data = acc[OUT_W-1:0] masked to fill bits, out_bits=fill, out_last=1), clear acc and fill, and return to ACCUM.
  - Exactly OUT_W remaining gives one final word with out_bits=OUT_W. No extra empty word follows.
  - fill=0 at FLUSH gives an empty terminator: out_bits=0, out_data=0, out_last=1.
- Output slot: out_data, out_bits and out_last hold while out_valid && !out_ready. out_valid drops after a handshake if no new load happens in that cycle.
- Reset asserted (any time, including mid-flush):
  - acc=0, fill=0, state=ACCUM.
  - out_valid=0, out_data=0, out_bits=0, out_last=0, in_ready=0.
  - Any partial stream is discarded.

## Timing
- The output is registered. A word completed by the code accepted at edge k is presented with out_valid=1 after edge k+1, provided the slot is free at that cycle.
- Sustained throughput is one code per cycle and one word per cycle. in_ready stays 1 under continuous out_ready=1 for any code lengths.
- Backpressure: with out_valid=1 and out_ready=0, the packer accepts codes until fill ≥ OUT_W. in_ready then falls combinationally from registered state.
- Flush latency after the last-code edge k, with out_ready=1:
  - final word valid after edge k+1 when fill ≤ OUT_W;
  - after edge k+2 when one full word precedes it.
- A new stream's first code is accepted in the cycle after the final word loads.
- in_ready, out_valid and out_last have no combinational path from in_valid, in_data or in_len. in_ready depends on out_ready.

## Test plan
- Reset: hold reset=0 with random inputs. All outputs stay 0. One cycle after release, in_ready=1.
- Small stream (OUT_W=64, IN_W=32): send 0x1/len1, then 0x3/len2 with in_last. Expect one word: out_data=0x7, out_bits=3, out_last=1.
- Masking and saturation: send in_data=0xFFFFFFFF/len4 with in_last. Expect out_data=0xF, out_bits=4. Repeat with in_len=40: treated as 32, out_bits=32.
- Full streaming: send codes A,B,C,D, each len 32, back to back with out_ready=1, last on D.
  - in_ready stays 1 throughout.
  - Expect word {B,A} with out_bits=64, out_last=0, then word {D,C} with out_bits=64, out_last=1.
  - No third word appears.
- Backpressure: hold out_ready=0 and send 0xAAAAAAAA/len32 ×4.
  - in_ready drops once the slot holds one word and fill=64.
  - Output data holds stable.
  - Release out_ready: words emerge in order with no loss or duplication.
- Empty stream and reset mid-flush:
  - in_last with len 0 at fill 0 gives one word: out_bits=0, out_data=0, out_last=1.
  - Assert reset while in FLUSH with out_valid=1: outputs clear immediately, and the next stream packs from bit 0.
